// File: rtl/instr_fetch_if.sv
// Instruction-memory read port of the fetch stage: registered req/addr out,
// ack/rdata back from memory.
interface instr_fetch_if #(
  parameter int unsigned PC_W = 16
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ack reads, IF/ID register with a
// one-entry skid buffer for stalls, and flush/redirect for taken branches.
module instr_fetch #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   branch_target,
  instr_fetch_if.master     imem,
  output logic [31:0]       instr,
  output logic [PC_W-1:0]   instr_pc,
  output logic              instr_valid
);

  // S_REQ: skid buffer empty, requesting; S_FULL: skid buffer holds a word
  typedef enum logic {
    S_REQ  = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t          r_state,    w_state;
  logic            r_req,      w_req;
  logic [PC_W-1:0] r_addr,     w_addr;
  logic [31:0]     r_instr,    w_instr;
  logic [PC_W-1:0] r_instr_pc, w_instr_pc;
  logic            r_valid,    w_valid;
  logic [31:0]     r_buf_data, w_buf_data;
  logic [PC_W-1:0] r_buf_pc,   w_buf_pc;
  logic            r_drop,     w_drop;
  logic [PC_W-1:0] r_next_pc,  w_next_pc;

  logic            w_ack;
  logic [PC_W-1:0] w_addr_inc;

  // An ack only counts while a request is actually on the bus
  assign w_ack      = imem.imem_ack && r_req;
  assign w_addr_inc = r_addr + PC_W'(1);

  always_comb begin
    w_state    = r_state;
    w_req      = r_req;
    w_addr     = r_addr;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    w_valid    = r_valid;
    w_buf_data = r_buf_data;
    w_buf_pc   = r_buf_pc;
    w_drop     = r_drop;
    w_next_pc  = r_next_pc;

    if (flush) begin
      w_instr = NOP;
      w_valid = 1'b0;
      w_state = S_REQ;
      w_req   = 1'b1;
      if (w_ack || !r_req) begin
        w_addr = branch_target;
        w_drop = 1'b0;
      end else begin
        // Request still in flight: keep the address stable, discard its data later
        w_drop    = 1'b1;
        w_next_pc = branch_target;
      end
    end else if (w_ack && r_drop) begin
      w_addr = r_next_pc;
      w_drop = 1'b0;
      if (!stall) begin
        w_instr = NOP;
        w_valid = 1'b0;
      end
    end else if (w_ack && !stall) begin
      w_instr    = imem.imem_rdata;
      w_instr_pc = r_addr;
      w_valid    = 1'b1;
      w_addr     = w_addr_inc;
    end else if (w_ack) begin
      w_buf_data = imem.imem_rdata;
      w_buf_pc   = r_addr;
      w_addr     = w_addr_inc;
      w_state    = S_FULL;
      w_req      = 1'b0;
    end else begin
      case (r_state)
        S_FULL: begin
          if (!stall) begin
            w_instr    = r_buf_data;
            w_instr_pc = r_buf_pc;
            w_valid    = 1'b1;
            w_state    = S_REQ;
            w_req      = 1'b1;
          end
        end
        default: begin
          w_req = 1'b1;
          if (!stall) begin
            w_instr = NOP;
            w_valid = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_instr    <= NOP;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_buf_data <= '0;
      r_buf_pc   <= '0;
      r_drop     <= 1'b0;
      r_next_pc  <= RESET_PC;
    end else begin
      r_state    <= w_state;
      r_req      <= w_req;
      r_addr     <= w_addr;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
      r_valid    <= w_valid;
      r_buf_data <= w_buf_data;
      r_buf_pc   <= w_buf_pc;
      r_drop     <= w_drop;
      r_next_pc  <= w_next_pc;
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_valid    = r_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized phase, checked
// cycle by cycle against a queue-based reference model of the fetch rules.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] branch_target;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;

  logic [31:0] w_instr;
  logic [15:0] w_instr_pc;
  logic        w_instr_valid;

  instr_fetch_if #(.PC_W(16)) bus ();
  instr_fetch_if #(.PC_W(16)) bus_w ();

  instr_fetch #(.PC_W(16), .RESET_PC(16'h0000), .NOP(NOP)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem(bus.master),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  // Second instance exercising the RESET_PC=0xFFFF wrap with zero-wait memory
  instr_fetch #(.PC_W(16), .RESET_PC(16'hFFFF), .NOP(NOP)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
    .branch_target(16'h0000), .imem(bus_w.master),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'd0:   mem_word = 32'h0fe00001;
      16'd1:   mem_word = 32'h0fe10002;
      16'd2:   mem_word = 32'h080122b2;
      16'd3:   mem_word = 32'h08642aa0;
      16'd4:   mem_word = 32'h088532a2;
      16'd5:   mem_word = 32'h13e6dfff;
      16'd6:   mem_word = 32'h08210aa5;
      16'd7:   mem_word = 32'h08432aa0;
      default: mem_word = {a ^ 16'hA5C3, ~a};
    endcase
  endfunction

  assign bus_w.imem_ack   = bus_w.imem_req;
  assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder policy
  int wait_n   = 0;
  int wcnt     = 0;
  bit rnd_mode = 1'b0;

  // Reference model state
  typedef struct packed {
    logic [31:0] data;
    logic [15:0] pc;
  } entry_t;

  bit          m_req;
  logic [15:0] m_addr;
  logic [31:0] m_instr;
  logic [15:0] m_pc;
  bit          m_valid;
  entry_t      m_skid[$];
  logic [15:0] m_redirect[$];
  bit          m_was_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit f,
                            input logic [15:0] tgt, input bit ack, input logic [31:0] rdata);
    bit     a;
    entry_t e;
    m_was_rst = r;
    if (r) begin
      m_req = 1'b0; m_addr = 16'h0000; m_instr = NOP; m_pc = 16'h0000; m_valid = 1'b0;
      m_skid.delete();
      m_redirect.delete();
      return;
    end
    a = ack && m_req;
    if (f) begin
      m_instr = NOP; m_valid = 1'b0;
      m_skid.delete();
      m_redirect.delete();
      if (a || !m_req) m_addr = tgt;
      else m_redirect.push_back(tgt);
    end else if (a && m_redirect.size() != 0) begin
      m_addr = m_redirect.pop_front();
    end else if (a) begin
      if (s) begin
        e.data = rdata; e.pc = m_addr;
        m_skid.push_back(e);
      end else begin
        m_instr = rdata; m_pc = m_addr; m_valid = 1'b1;
      end
      m_addr = m_addr + 16'd1;
    end else if (!s) begin
      if (m_skid.size() != 0) begin
        e = m_skid.pop_front();
        m_instr = e.data; m_pc = e.pc; m_valid = 1'b1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    // Memory is requested exactly when there is room for the returned word
    m_req = (m_skid.size() == 0);
  endtask

  // One clock: drive inputs, respond as memory, advance model, check after the edge.
  // ackf: -1 follows the responder policy, 0/1 forces imem_ack.
  task automatic tick(input bit r, input bit s, input bit f, input logic [15:0] tgt, input int ackf);
    bit          a;
    bit          req_before;
    logic [31:0] rdata;
    rst = r; stall = s; flush = f; branch_target = tgt;
    req_before = bus.imem_req;
    if (ackf >= 0)         a = ackf[0];
    else if (req_before)   a = rnd_mode ? ($urandom_range(0, 2) == 0) : (wcnt >= wait_n);
    else                   a = rnd_mode && ($urandom_range(0, 1) == 1);
    rdata = (a && req_before) ? mem_word(bus.imem_addr) : $urandom();
    bus.imem_ack   = a;
    bus.imem_rdata = rdata;
    model_step(r, s, f, tgt, a, rdata);
    @(posedge clk);
    #1;
    if (req_before && a)  wcnt = 0;
    else if (req_before)  wcnt++;
    else                  wcnt = 0;
    chk("imem_req",    32'(bus.imem_req),  32'(m_req));
    chk("imem_addr",   32'(bus.imem_addr), 32'(m_addr));
    chk("instr_valid", 32'(instr_valid),   32'(m_valid));
    chk("instr",       instr,              m_instr);
    if (m_valid || m_was_rst) chk("instr_pc", 32'(instr_pc), 32'(m_pc));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;

    // Reset held for two cycles, then release
    tick(1, 0, 0, 16'h0, 0);
    tick(1, 0, 0, 16'h0, 0);
    tick(0, 0, 0, 16'h0, 0);
    chk("wrap_req_k1",  32'(bus_w.imem_req),  32'd1);
    chk("wrap_addr_k1", 32'(bus_w.imem_addr), 32'h0000FFFF);

    // Zero-wait stream of the eight program words
    wait_n = 0; rnd_mode = 1'b0; wcnt = 0;
    tick(0, 0, 0, 16'h0, -1);
    chk("wrap_instr_k2", w_instr,             mem_word(16'hFFFF));
    chk("wrap_pc_k2",    32'(w_instr_pc),     32'h0000FFFF);
    chk("wrap_addr_k2",  32'(bus_w.imem_addr), 32'h00000000);
    tick(0, 0, 0, 16'h0, -1);
    chk("wrap_instr_k3", w_instr,             mem_word(16'h0000));
    chk("wrap_pc_k3",    32'(w_instr_pc),     32'h00000000);
    chk("wrap_valid_k3", 32'(w_instr_valid),  32'd1);
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 16'h0, -1);

    // Stall with skid: back to 0, stall while word 4 is acked
    tick(0, 0, 1, 16'h0000, -1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 16'h0, -1);
    tick(0, 1, 0, 16'h0, -1);
    tick(0, 1, 0, 16'h0, -1);
    tick(0, 1, 0, 16'h0, 1);
    tick(0, 0, 0, 16'h0, -1);
    tick(0, 0, 0, 16'h0, -1);
    tick(0, 0, 0, 16'h0, -1);

    // Flush during outstanding request to 5; flush+stall, then a second flush
    tick(0, 0, 1, 16'h0005, -1);
    wait_n = 3;
    tick(0, 0, 0, 16'h0, -1);
    tick(0, 1, 1, 16'h0200, -1);
    tick(0, 0, 1, 16'h0100, -1);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 16'h0, -1);

    // Two wait cycles per request
    wait_n = 2;
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 16'h0, -1);

    // Address wrap through redirect
    wait_n = 0;
    tick(0, 0, 1, 16'hFFFE, -1);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 16'h0, -1);

    // Randomized traffic
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, 16'($urandom()), -1);
    end

    // Reset during an outstanding request with a late ack
    rnd_mode = 1'b0; wait_n = 3;
    tick(1, 0, 0, 16'h0, 0);
    tick(0, 0, 0, 16'h0, 0);
    tick(0, 0, 0, 16'h0, 0);
    tick(1, 0, 0, 16'h0, 0);
    tick(1, 0, 0, 16'h0, 1);
    tick(0, 0, 0, 16'h0, 1);
    tick(0, 0, 0, 16'h0, 1);
    tick(0, 0, 0, 16'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage feeding the Control decoder. It maintains the program counter and issues word reads to instruction memory over a req/ack handshake. Returned words go into an IF/ID register whose `instr` output drives Control's `instr` input directly. It supports pipeline stall from downstream hazard logic, with a one-entry skid buffer, and flush/redirect for taken branches.

## Interface
- `PC_W`, 16: program counter / instruction memory word-address width.
- `RESET_PC`, 0: first fetch address after reset.
- `NOP`, 32'h00000000: instruction word inserted on reset and flush.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold IF/ID contents (downstream not accepting).
- `flush`  in  1  discard fetched/in-flight words and redirect to `branch_target`.
- `branch_target`  in  PC_W  redirect word address, sampled when `flush`=1.
- `imem_req`  out  1  read request, registered.
- `imem_addr`  out  PC_W  read word address, registered, stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  memory completes the read this cycle.
- `imem_rdata`  in  32  read data, valid when `imem_ack`=1.
- `instr`  out  32  IF/ID instruction word to Control.
- `instr_pc`  out  PC_W  address of `instr`.
- `instr_valid`  out  1  `instr` is a real fetched word, not a bubble.

## Operation
- Addresses are words; the next address is `imem_addr+1` modulo 2^PC_W.
- States:
  - REQ: `imem_req`=1.
  - FULL: skid buffer occupied, `imem_req`=0.
- Internal `drop` flag: the next ack is discarded. Internal `next_pc` holds a pending redirect.
- Per edge, priority order:
  1. `rst`: `imem_req`=0, `imem_addr`=RESET_PC, `instr`=NOP, `instr_pc`=0, `instr_valid`=0, buffer empty, `drop`=0, state REQ. `imem_req` rises on the first edge after reset release.
  2. `flush`: `instr`<=NOP, `instr_valid`<=0, buffer cleared, state REQ.
     - If `imem_ack`=1 or no request is outstanding: data discarded, `imem_addr`<=`branch_target`.
     - If the request is outstanding without ack: `drop`<=1, `next_pc`<=`branch_target`, address held.
     - `flush` overrides `stall`.
  3. Ack with `drop`=1: data discarded, `imem_addr`<=`next_pc`, `drop`<=0.
  4. Ack with `stall`=0 and buffer empty: IF/ID <= {`imem_rdata`, `imem_addr`, valid=1}, `imem_addr`<=+1.
  5. Ack with `stall`=1: buffer <= {`imem_rdata`, `imem_addr`}, `imem_addr`<=+1, state FULL, `imem_req`<=0.
  6. In FULL with `stall`=0: IF/ID <= buffer, valid=1, buffer empty, state REQ.
  7. `stall`=0 with no ack and an empty buffer: IF/ID <= NOP with valid=0. A bubble enters, and the previous word is consumed.
  8. `stall`=1 with no ack: IF/ID unchanged.
- `imem_ack` while `imem_req`=0 is ignored.
- A second flush while `drop`=1 overwrites `next_pc`; `drop` stays set.

## Timing
- Zero-wait memory (`imem_ack` high in every request cycle) gives one instruction per cycle.
- Latency from first request to `instr` is 1 cycle: data captured at the ack edge is visible on `instr` in the following cycle.
- Each additional memory wait cycle inserts one bubble (`instr_valid`=0).
- Stall release with a full buffer:
  - Buffered word appears 1 cycle after `stall` falls.
  - `imem_req` reasserts in that same cycle.
  - The fetch after it arrives no earlier than 1 cycle later.
- Flush to first target word on `instr` is at least 2 cycles with zero-wait memory.
- Flush during an outstanding request costs the remaining wait of the dropped request.
- Reset mid-request abandons the request; the ack arriving during or after reset with `imem_req`=0 is ignored.

## Test plan
- Reset: hold `rst` for 2 cycles → `instr`=0, `instr_valid`=0, `imem_req`=0. One cycle after release: `imem_req`=1, `imem_addr`=0.
- Zero-wait stream: memory returns 0x0fe00001, 0x0fe10002, 0x080122b2, 0x08642aa0, 0x088532a2, 0x13e6dfff, 0x08210aa5, 0x08432aa0 at addresses 0..7 → `instr` presents them on 8 consecutive cycles with `instr_pc` 0..7, `instr_valid`=1.
- Wait states: ack after 2 wait cycles per request → `imem_addr` held stable and valid word every 3rd cycle, bubbles (NOP, valid=0) between.
- Stall with skid: stall at address 3 while ack of word 4 arrives → `instr` holds 0x08642aa0, `imem_req` drops. Release → 0x088532a2 (pc 4) next cycle, fetch resumes at 5.
- Flush mid-request: flush with `branch_target`=0x0100 while the request to address 5 is outstanding → 0x13e6dfff never appears. After the ack, `imem_addr`=0x0100, and next valid `instr_pc`=0x0100. Flush+stall in the same cycle → flush wins.
- Wrap and reset mid-operation: RESET_PC=0xFFFF, PC_W=16 → the address after 0xFFFF is 0x0000. Assert `rst` during an outstanding request with a delayed ack → ack ignored, fetch restarts at RESET_PC.
